// File: rtl/ddr4_cmd_sequencer.sv
// Single-request DDR4 command sequencer: ACT -> RD/WR -> burst -> PRE, one open row at a time.
// Command/control outputs are registered from the next state; dq_out follows wdata during write beats.
module ddr4_cmd_sequencer #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BGWIDTH       = $clog2(BANKGROUPS),
  parameter int BANKSPERGROUP = 4,
  parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
  parameter int COLS          = 1024,
  parameter int CADDRWIDTH    = $clog2(COLS),
  parameter int DQWIDTH       = 72,
  parameter int BL            = 8,
  parameter int T_RCD         = 15,
  parameter int T_CL          = 15,
  parameter int T_CWL         = 11,
  parameter int T_RP          = 15,
  parameter int INIT_CYCLES   = 5
) (
  input  logic                  ck_t,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  input  logic [DQWIDTH-1:0]    wdata,
  output logic                  wdata_ready,
  output logic                  rd_strobe,
  output logic                  busy,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH:0]      bg,
  output logic [BAWIDTH:0]      ba,
  output logic [DQWIDTH-1:0]    dq_out,
  output logic                  dq_oe
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] CL_LAST   = CNT_W'(T_CL - 2);
  localparam logic [CNT_W-1:0] CWL_LAST  = CNT_W'(T_CWL - 2);
  localparam logic [CNT_W-1:0] BL_LAST   = CNT_W'(BL - 1);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(T_RP - 2);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_ACT, ST_TRCD, ST_CAS, ST_CASLAT, ST_BURST, ST_PRE, ST_TRP
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    accept_s;
  logic                    wr_r, wr_s;
  logic [BGWIDTH-1:0]      bg_lat_r, bg_lat_s;
  logic [BAWIDTH-1:0]      ba_lat_r, ba_lat_s;
  logic [ADDRWIDTH-1:0]    row_r, row_s;
  logic [CADDRWIDTH-1:0]   col_r, col_s;

  logic                    cke_r, cs_n_r, cs_n_s, act_n_r, act_n_s;
  logic [ADDRWIDTH-1:0]    a_r, a_s;
  logic [BGWIDTH:0]        bg_r, bg_s;
  logic [BAWIDTH:0]        ba_r, ba_s;
  logic                    dq_oe_r, dq_oe_s, wdata_ready_r, wdata_ready_s;
  logic                    rd_strobe_r, rd_strobe_s, req_ready_r, req_ready_s, busy_r, busy_s;

  // A16..A14 carry RAS_n/CAS_n/WE_n; A10 low selects no auto-precharge
  function automatic logic [ADDRWIDTH-1:0] cas_addr(input logic wr, input logic [CADDRWIDTH-1:0] col);
    logic [ADDRWIDTH-1:0] a;
    a = {ADDRWIDTH{1'b0}};
    a[CADDRWIDTH-1:0] = col;
    a[10] = 1'b0;
    if (wr) begin
      a[16:14] = 3'b100;
    end else begin
      a[16:14] = 3'b101;
    end
    return a;
  endfunction

  function automatic logic [ADDRWIDTH-1:0] pre_addr();
    logic [ADDRWIDTH-1:0] a;
    a = {ADDRWIDTH{1'b0}};
    a[16:14] = 3'b010;
    return a;
  endfunction

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // Request fields as they will be after this edge (fresh on acceptance)
  always_comb begin
    if (accept_s) begin
      wr_s     = req_write;
      bg_lat_s = req_bg;
      ba_lat_s = req_ba;
      row_s    = req_row;
      col_s    = req_col;
    end else begin
      wr_s     = wr_r;
      bg_lat_s = bg_lat_r;
      ba_lat_s = ba_lat_r;
      row_s    = row_r;
      col_s    = col_r;
    end
  end

  // State, counter and latched request registers
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_INIT;
      cnt_r    <= {CNT_W{1'b0}};
      wr_r     <= 1'b0;
      bg_lat_r <= {BGWIDTH{1'b0}};
      ba_lat_r <= {BAWIDTH{1'b0}};
      row_r    <= {ADDRWIDTH{1'b0}};
      col_r    <= {CADDRWIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      wr_r     <= wr_s;
      bg_lat_r <= bg_lat_s;
      ba_lat_r <= ba_lat_s;
      row_r    <= row_s;
      col_r    <= col_s;
    end
  end

  // Next state; the counter restarts from zero on every state change
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT:   if (cnt_r == INIT_LAST) state_s = ST_IDLE; else state_s = ST_INIT;
      ST_IDLE:   if (req_valid) state_s = ST_ACT; else state_s = ST_IDLE;
      ST_ACT:    state_s = ST_TRCD;
      ST_TRCD:   if (cnt_r == TRCD_LAST) state_s = ST_CAS; else state_s = ST_TRCD;
      ST_CAS:    state_s = ST_CASLAT;
      ST_CASLAT: if (cnt_r == (wr_r ? CWL_LAST : CL_LAST)) state_s = ST_BURST; else state_s = ST_CASLAT;
      ST_BURST:  if (cnt_r == BL_LAST) state_s = ST_PRE; else state_s = ST_BURST;
      ST_PRE:    state_s = ST_TRP;
      ST_TRP:    if (cnt_r == TRP_LAST) state_s = ST_IDLE; else state_s = ST_TRP;
      default:   state_s = ST_INIT;
    endcase
    if (state_s != state_r) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output decode from the next state so the registered pins line up with it
  always_comb begin
    cs_n_s        = 1'b1;
    act_n_s       = 1'b1;
    a_s           = {ADDRWIDTH{1'b0}};
    bg_s          = bg_r;
    ba_s          = ba_r;
    dq_oe_s       = 1'b0;
    wdata_ready_s = 1'b0;
    rd_strobe_s   = 1'b0;
    req_ready_s   = (state_s == ST_IDLE);
    busy_s        = (state_s != ST_IDLE) && (state_s != ST_INIT);
    case (state_s)
      ST_ACT: begin
        cs_n_s  = 1'b0;
        act_n_s = 1'b0;
        a_s     = row_s;
        bg_s    = {1'b0, bg_lat_s};
        ba_s    = {1'b0, ba_lat_s};
      end
      ST_CAS: begin
        cs_n_s = 1'b0;
        a_s    = cas_addr(wr_s, col_s);
        bg_s   = {1'b0, bg_lat_s};
        ba_s   = {1'b0, ba_lat_s};
      end
      ST_PRE: begin
        cs_n_s = 1'b0;
        a_s    = pre_addr();
        bg_s   = {1'b0, bg_lat_s};
        ba_s   = {1'b0, ba_lat_s};
      end
      ST_BURST: begin
        if (wr_s) begin
          dq_oe_s       = 1'b1;
          wdata_ready_s = 1'b1;
        end else begin
          rd_strobe_s   = 1'b1;
        end
      end
      default: begin
        cs_n_s = 1'b1;
      end
    endcase
  end

  // Registered DIMM and handshake outputs
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      cke_r         <= 1'b0;
      cs_n_r        <= 1'b1;
      act_n_r       <= 1'b1;
      a_r           <= {ADDRWIDTH{1'b0}};
      bg_r          <= {(BGWIDTH+1){1'b0}};
      ba_r          <= {(BAWIDTH+1){1'b0}};
      dq_oe_r       <= 1'b0;
      wdata_ready_r <= 1'b0;
      rd_strobe_r   <= 1'b0;
      req_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      cke_r         <= 1'b1;
      cs_n_r        <= cs_n_s;
      act_n_r       <= act_n_s;
      a_r           <= a_s;
      bg_r          <= bg_s;
      ba_r          <= ba_s;
      dq_oe_r       <= dq_oe_s;
      wdata_ready_r <= wdata_ready_s;
      rd_strobe_r   <= rd_strobe_s;
      req_ready_r   <= req_ready_s;
      busy_r        <= busy_s;
    end
  end

  // Write data passes straight through while a write beat is on the bus
  always_comb begin
    if ((state_r == ST_BURST) && wr_r) begin
      dq_out = wdata;
    end else begin
      dq_out = {DQWIDTH{1'b0}};
    end
  end

  assign cke         = cke_r;
  assign cs_n        = cs_n_r;
  assign act_n       = act_n_r;
  assign A           = a_r;
  assign bg          = bg_r;
  assign ba          = ba_r;
  assign dq_oe       = dq_oe_r;
  assign wdata_ready = wdata_ready_r;
  assign rd_strobe   = rd_strobe_r;
  assign req_ready   = req_ready_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: per-request timing/address table plus init, back-to-back and reset corners.
// Offsets are counted in cycles from the ACT cycle (k = 0), sampled on the falling edge.
module tb_ddr4_cmd_sequencer;

  logic        ck_t, reset_n, req_valid, req_ready, req_write;
  logic [1:0]  req_bg, req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic [71:0] wdata, dq_out;
  logic        wdata_ready, rd_strobe, busy, cke, cs_n, act_n, dq_oe;
  logic [16:0] A;
  logic [2:0]  bg, ba;

  int n_vec = 0;
  int n_bad = 0;
  int last_pre_off, last_ready_off;

  ddr4_cmd_sequencer dut (
    .ck_t(ck_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .wdata(wdata), .wdata_ready(wdata_ready), .rd_strobe(rd_strobe),
    .busy(busy), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .dq_out(dq_out), .dq_oe(dq_oe)
  );

  initial begin
    ck_t = 1'b0;
    forever #5 ck_t = ~ck_t;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  bgi, bai;
    logic [16:0] row;
    logic [9:0]  col;
    logic [16:0] e_act_a, e_cas_a;
    logic [2:0]  e_bg, e_ba;
    int          e_cas, e_beat, e_pre, e_ready;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [71:0] wpat(input int k);
    return {8'hC3, 32'(k) * 32'h9E37_79B9, 32'(k) ^ 32'h1234_5678};
  endfunction

  // Issue one request and follow it to the return of req_ready
  task automatic run_txn(input vec_t v, input logic hold, input string nm);
    int act_cnt, act_off, cas_off, pre_off, ready_off, beat_err, ctrl_err;
    logic [16:0] act_a, cas_a, pre_a;
    logic [2:0] act_bg, act_ba;
    logic exp_beat, exp_cmd;
    act_cnt = 0; act_off = -1; cas_off = -1; pre_off = -1; ready_off = -1;
    beat_err = 0; ctrl_err = 0;
    act_a = 17'h0; cas_a = 17'h0; pre_a = 17'h0; act_bg = 3'h0; act_ba = 3'h0;
    req_valid = 1'b1; req_write = v.wr; req_bg = v.bgi; req_ba = v.bai;
    req_row = v.row; req_col = v.col;
    for (int k = 0; k < 120; k++) begin
      @(posedge ck_t);
      #1;
      if (!hold) req_valid = 1'b0;
      wdata = wpat(k);
      @(negedge ck_t);
      exp_beat = (k >= v.e_beat) && (k < v.e_beat + 8);
      exp_cmd  = (k == 0) || (k == v.e_cas) || (k == v.e_pre);
      if (!cs_n && !act_n) begin
        act_cnt++;
        if (act_off < 0) begin act_off = k; act_a = A; act_bg = bg; act_ba = ba; end
      end
      if (!cs_n && act_n && A[16:14] != 3'b010) begin cas_off = k; cas_a = A; end
      if (!cs_n && act_n && A[16:14] == 3'b010) begin pre_off = k; pre_a = A; end
      if (rd_strobe !== (!v.wr && exp_beat) || dq_oe !== (v.wr && exp_beat) ||
          wdata_ready !== (v.wr && exp_beat) ||
          dq_out !== ((v.wr && exp_beat) ? wdata : 72'h0)) beat_err++;
      if (cs_n !== !exp_cmd || cke !== 1'b1 || bg !== v.e_bg || ba !== v.e_ba) ctrl_err++;
      if (!exp_cmd && (A !== 17'h0 || act_n !== 1'b1)) ctrl_err++;
      if (busy !== (k < v.e_ready) || req_ready !== (k >= v.e_ready)) ctrl_err++;
      if (req_ready) begin ready_off = k; break; end
    end
    check({nm, " act_off"}, 72'(act_off), 72'(0));
    check({nm, " act_cnt"}, 72'(act_cnt), 72'(1));
    check({nm, " act_A"},   72'(act_a),   72'(v.e_act_a));
    check({nm, " act_bg"},  72'(act_bg),  72'(v.e_bg));
    check({nm, " act_ba"},  72'(act_ba),  72'(v.e_ba));
    check({nm, " cas_off"}, 72'(cas_off), 72'(v.e_cas));
    check({nm, " cas_A"},   72'(cas_a),   72'(v.e_cas_a));
    check({nm, " pre_off"}, 72'(pre_off), 72'(v.e_pre));
    check({nm, " pre_A"},   72'(pre_a),   72'(17'h08000));
    check({nm, " ready_off"}, 72'(ready_off), 72'(v.e_ready));
    check({nm, " beat_errs"}, 72'(beat_err), 72'(0));
    check({nm, " ctrl_errs"}, 72'(ctrl_err), 72'(0));
    last_pre_off = pre_off;
    last_ready_off = ready_off;
  endtask

  // Reset release followed by the INIT window
  task automatic init_seq(input string nm);
    int cs_low;
    cs_low = 0;
    @(negedge ck_t);
    reset_n = 1'b1;
    check({nm, " ready_i0"}, 72'(req_ready), 72'(0));
    check({nm, " cke_i0"}, 72'(cke), 72'(0));
    for (int i = 1; i <= 5; i++) begin
      @(negedge ck_t);
      if (!cs_n) cs_low++;
      check($sformatf("%s ready_i%0d", nm, i), 72'(req_ready), 72'(i == 5));
      check($sformatf("%s cke_i%0d", nm, i), 72'(cke), 72'(1));
    end
    check({nm, " cs_low"}, 72'(cs_low), 72'(0));
  endtask

  initial begin
    int cs_low, k;
    vecs[0] = '{1'b0, 2'd1, 2'd1, 17'h00001, 10'h000, 17'h00001, 17'h14000, 3'b001, 3'b001, 15, 30, 38, 53};
    vecs[1] = '{1'b1, 2'd1, 2'd1, 17'h00001, 10'h000, 17'h00001, 17'h10000, 3'b001, 3'b001, 15, 26, 34, 49};
    vecs[2] = '{1'b0, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 17'h1FFFF, 17'h143FF, 3'b011, 3'b011, 15, 30, 38, 53};
    vecs[3] = '{1'b1, 2'd2, 2'd0, 17'h0AAAA, 10'h2AA, 17'h0AAAA, 17'h102AA, 3'b010, 3'b000, 15, 26, 34, 49};
    vecs[4] = '{1'b0, 2'd0, 2'd2, 17'h15555, 10'h155, 17'h15555, 17'h14155, 3'b000, 3'b010, 15, 30, 38, 53};
    vecs[5] = '{1'b1, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 17'h1FFFF, 17'h103FF, 3'b011, 3'b011, 15, 26, 34, 49};

    reset_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = 2'd0; req_ba = 2'd0;
    req_row = 17'h0; req_col = 10'h0; wdata = 72'h0;
    #2 reset_n = 1'b0;
    @(negedge ck_t);
    check("rst cke", 72'(cke), 72'(0));
    check("rst cs_n", 72'(cs_n), 72'(1));
    check("rst act_n", 72'(act_n), 72'(1));
    check("rst A", 72'(A), 72'(0));
    check("rst bg_ba", 72'({bg, ba}), 72'(0));
    check("rst strobes", 72'({dq_oe, wdata_ready, rd_strobe, req_ready, busy}), 72'(0));
    init_seq("init");

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0, $sformatf("v%0d", i));

    // req_valid held through a read: one ACT, then the next ACT right after IDLE
    run_txn(vecs[0], 1'b1, "b2b");
    @(posedge ck_t);
    #1 req_valid = 1'b0;
    @(negedge ck_t);
    check("b2b act2", 72'({cs_n, act_n}), 72'(2'b00));
    check("b2b act2_A", 72'(A), 72'(17'h00001));
    check("b2b gap_ok", 72'((last_ready_off + 1 - last_pre_off) >= 15), 72'(1));
    k = 0;
    while (!req_ready && k < 100) begin @(negedge ck_t); k++; end
    check("b2b drain", 72'(req_ready), 72'(1));

    // Reset in the middle of a write burst
    req_valid = 1'b1; req_write = 1'b1; req_bg = 2'd1; req_ba = 2'd1;
    req_row = 17'h00001; req_col = 10'h000;
    for (int j = 0; j <= 28; j++) begin
      @(posedge ck_t);
      #1 req_valid = 1'b0;
      wdata = wpat(j);
      @(negedge ck_t);
    end
    check("mid dq_oe_before", 72'(dq_oe), 72'(1));
    reset_n = 1'b0;
    #1;
    check("mid dq_oe", 72'(dq_oe), 72'(0));
    check("mid cs_n", 72'(cs_n), 72'(1));
    check("mid dq_out", dq_out, 72'h0);
    check("mid outs", 72'({cke, wdata_ready, rd_strobe, req_ready, busy}), 72'(0));
    @(negedge ck_t);
    init_seq("reinit");
    cs_low = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge ck_t);
      if (!cs_n) cs_low++;
    end
    check("mid no_pre", 72'(cs_low), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
